// File: rtl/perf_counter_bank.sv
// Bank of NUM_EVENTS wrapping event counters with sticky overflow flags and a
// serial ready/valid dump port. Define PERF_SNAPSHOT_EN to dump from a shadow copy.
module perf_counter_bank #(
    parameter int NUM_EVENTS = 8,
    parameter int CNT_WIDTH  = 48,
    parameter int INC_WIDTH  = 3,
    localparam int IDX_WIDTH = (NUM_EVENTS > 1) ? $clog2(NUM_EVENTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            en,
    input  logic                            clear,
    input  logic [NUM_EVENTS*INC_WIDTH-1:0] inc,
    output logic [NUM_EVENTS-1:0]           ovf,
    input  logic                            dump_req,
    output logic                            busy,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [IDX_WIDTH-1:0]            out_idx,
    output logic [CNT_WIDTH-1:0]            out_data,
    output logic                            dump_done
);

    typedef enum logic {
        IDLE,
        DUMP
    } state_t;

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(NUM_EVENTS - 1);

    state_t                 state_q, state_d;
    logic [IDX_WIDTH-1:0]   idx_q, idx_d;
    logic                   done_d;
    logic [CNT_WIDTH-1:0]   cnt_q [NUM_EVENTS];
    logic [CNT_WIDTH-1:0]   cnt_d [NUM_EVENTS];
    logic [CNT_WIDTH:0]     sum   [NUM_EVENTS];
    logic [NUM_EVENTS-1:0]  ovf_d;

    // The extra sum bit is the carry out, i.e. the wrap indication.
    always_comb begin
        ovf_d = ovf;
        for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
            sum[i]   = {1'b0, cnt_q[i]} + (CNT_WIDTH + 1)'(inc[i*INC_WIDTH +: INC_WIDTH]);
            cnt_d[i] = cnt_q[i];
            if (clear) begin
                cnt_d[i] = '0;
                ovf_d[i] = 1'b0;
            end else if (en) begin
                cnt_d[i] = sum[i][CNT_WIDTH-1:0];
                if (sum[i][CNT_WIDTH]) begin
                    ovf_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i] <= '0;
            end
            ovf <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            ovf <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = DUMP;
                    idx_d   = '0;
                end
            end
            DUMP: begin
                if (out_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        idx_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_WIDTH'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            dump_done <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            dump_done <= done_d;
        end
    end

    assign busy      = (state_q == DUMP);
    assign out_valid = (state_q == DUMP);
    assign out_idx   = idx_q;

`ifdef PERF_SNAPSHOT_EN
    logic [CNT_WIDTH-1:0] shadow_q [NUM_EVENTS];
    logic                 snap;

    // Capture post-update values so the dump reflects the accept cycle itself.
    assign snap = (state_q == IDLE) && dump_req;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
                shadow_q[i] <= '0;
            end
        end else if (snap) begin
            for (int unsigned i = 0; i < NUM_EVENTS; i++) begin
                shadow_q[i] <= cnt_d[i];
            end
        end
    end

    assign out_data = shadow_q[idx_q];
`else
    assign out_data = cnt_q[idx_q];
`endif

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed self-checking bench for perf_counter_bank (8 events, 8-bit counters,
// 3-bit increments); counter values are observed through the dump port.
module tb_perf_counter_bank;

    localparam int N  = 8;
    localparam int W  = 8;
    localparam int IW = 3;
    localparam int XW = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en = 1'b0;
    logic          clear = 1'b0;
    logic [N*IW-1:0] inc = '0;
    logic [N-1:0]  ovf;
    logic          dump_req = 1'b0;
    logic          busy;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [XW-1:0] out_idx;
    logic [W-1:0]  out_data;
    logic          dump_done;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] dd [N];
    int beats;
    int dones;

    always #5 clk = ~clk;

    perf_counter_bank #(
        .NUM_EVENTS(N),
        .CNT_WIDTH (W),
        .INC_WIDTH (IW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .clear    (clear),
        .inc      (inc),
        .ovf      (ovf),
        .dump_req (dump_req),
        .busy     (busy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_idx  (out_idx),
        .out_data (out_data),
        .dump_done(dump_done)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N*IW-1:0] slice(input int i, input int v);
        logic [N*IW-1:0] r;
        r = '0;
        r[i*IW +: IW] = IW'(v);
        return r;
    endfunction

    // Full dump at out_ready=1; fills dd, beats, dones.
    task automatic run_dump;
        for (int i = 0; i < N; i++) dd[i] = '0;
        beats = 0;
        dones = 0;
        out_ready = 1'b1;
        dump_req = 1'b1;
        tick;
        dump_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dump_done) dones++;
            if (out_valid) begin
                dd[out_idx] = out_data;
                beats++;
            end
            tick;
        end
    endtask

    task automatic test_reset;
        tick;
        tick;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++; if (dump_done !== 1'b0) begin n_fail++; $display("FAIL reset_dump_done: got %b expected 0", dump_done); end
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL reset_ovf: got %h expected 00", ovf); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL reset_out_idx: got %0d expected 0", out_idx); end
        n_checks++; if (out_data !== 8'd0) begin n_fail++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_count;
        en = 1'b1;
        inc = slice(2, 5);
        repeat (10) tick;
        en = 1'b0;
        inc = '0;
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL count_ovf: got %h expected 00", ovf); end
        run_dump;
        for (int i = 0; i < N; i++) begin
            n_checks++;
            if (dd[i] !== ((i == 2) ? 8'd50 : 8'd0)) begin
                n_fail++; $display("FAIL count_cnt%0d: got %0d expected %0d", i, dd[i], (i == 2) ? 50 : 0);
            end
        end
        n_checks++; if (beats !== 8) begin n_fail++; $display("FAIL count_beats: got %0d expected 8", beats); end
        n_checks++; if (dones !== 1) begin n_fail++; $display("FAIL count_dones: got %0d expected 1", dones); end
    endtask

    task automatic test_wrap;
        clear = 1'b1; tick; clear = 1'b0;
        en = 1'b1;
        inc = slice(0, 7);
        repeat (36) tick;
        inc = slice(0, 2);
        tick;
        en = 1'b0;
        inc = '0;
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL wrap_ovf_at_254: got %h expected 00", ovf); end
        run_dump;
        n_checks++; if (dd[0] !== 8'd254) begin n_fail++; $display("FAIL wrap_preload: got %0d expected 254", dd[0]); end
        en = 1'b1;
        inc = slice(0, 3);
        tick;
        en = 1'b0;
        inc = '0;
        n_checks++; if (ovf !== 8'h01) begin n_fail++; $display("FAIL wrap_ovf_set: got %h expected 01", ovf); end
        run_dump;
        n_checks++; if (dd[0] !== 8'd1) begin n_fail++; $display("FAIL wrap_value: got %0d expected 1", dd[0]); end
        n_checks++; if (ovf !== 8'h01) begin n_fail++; $display("FAIL wrap_ovf_sticky: got %h expected 01", ovf); end
        clear = 1'b1; tick; clear = 1'b0;
        n_checks++; if (ovf !== 8'h00) begin n_fail++; $display("FAIL wrap_ovf_clear: got %h expected 00", ovf); end
        run_dump;
        n_checks++; if (dd[0] !== 8'd0) begin n_fail++; $display("FAIL wrap_clear_value: got %0d expected 0", dd[0]); end
    endtask

    task automatic test_clear_override;
        en = 1'b1;
        inc = slice(1, 3);
        repeat (2) tick;
        en = 1'b0;
        inc = '0;
        run_dump;
        n_checks++; if (dd[1] !== 8'd6) begin n_fail++; $display("FAIL clr_pre: got %0d expected 6", dd[1]); end
        en = 1'b1;
        clear = 1'b1;
        inc = slice(1, 7);
        tick;
        clear = 1'b0;
        en = 1'b0;
        inc = '0;
        run_dump;
        n_checks++; if (dd[1] !== 8'd0) begin n_fail++; $display("FAIL clr_override: got %0d expected 0", dd[1]); end
    endtask

    task automatic test_dump_stall;
        int rem [N];
        int v;
        int exp_idx;
        int nd;
        clear = 1'b1; tick; clear = 1'b0;
        for (int i = 0; i < N; i++) rem[i] = 10 + i;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < N; i++) begin
                v = (rem[i] > 7) ? 7 : rem[i];
                rem[i] -= v;
                inc[i*IW +: IW] = IW'(v);
            end
            en = 1'b1;
            tick;
        end
        en = 1'b0;
        inc = '0;
        exp_idx = 0;
        nd = 0;
        dump_req = 1'b1;
        out_ready = 1'b1;
        tick;
        dump_req = 1'b0;
        for (int c = 0; c < 40; c++) begin
            out_ready = (c % 2 == 0);
            if (dump_done) begin
                nd++;
                n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_at_done: got %b expected 0", busy); end
            end
            if (out_valid) begin
                n_checks++; if (int'(out_idx) !== exp_idx) begin n_fail++; $display("FAIL stall_idx: got %0d expected %0d", out_idx, exp_idx); end
                n_checks++; if (int'(out_data) !== 10 + exp_idx) begin n_fail++; $display("FAIL stall_data: got %0d expected %0d", out_data, 10 + exp_idx); end
                if (out_ready) exp_idx++;
            end
            tick;
        end
        n_checks++; if (exp_idx !== 8) begin n_fail++; $display("FAIL stall_beats: got %0d expected 8", exp_idx); end
        n_checks++; if (nd !== 1) begin n_fail++; $display("FAIL stall_dones: got %0d expected 1", nd); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_busy_after: got %b expected 0", busy); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_valid_after: got %b expected 0", out_valid); end
    endtask

    task automatic test_back_to_back;
        bit found;
        found = 1'b0;
        out_ready = 1'b1;
        dump_req = 1'b1;
        tick;
        dump_req = 1'b0;
        for (int c = 0; c < 30; c++) begin
            if (dump_done) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL b2b_done_seen: got %b expected 1", found); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_at_done: got %b expected 0", busy); end
        dump_req = 1'b1;
        tick;
        dump_req = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %b expected 1", busy); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL b2b_idx: got %0d expected 0", out_idx); end
        n_checks++; if (dump_done !== 1'b0) begin n_fail++; $display("FAIL b2b_done_pulse: got %b expected 0", dump_done); end
        repeat (12) tick;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_drain: got %b expected 0", busy); end
    endtask

    task automatic test_snapshot;
        int m;
        int mv;
        int val;
        bit found;
        found = 1'b0;
        val = 0;
        mv = 0;
        clear = 1'b1; tick; clear = 1'b0;
        en = 1'b1;
        inc = slice(3, 7);
        repeat (14) tick;
        inc = slice(3, 2);
        tick;
        inc = slice(3, 1);
        m = 100;
        out_ready = 1'b0;
        dump_req = 1'b1;
        tick; m++;
        dump_req = 1'b0;
        repeat (5) begin tick; m++; end
        out_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_idx == 3'd3) begin
                val = int'(out_data);
                mv = m;
                found = 1'b1;
                break;
            end
            tick; m++;
        end
        en = 1'b0;
        inc = '0;
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL snap_beat3_seen: got %b expected 1", found); end
`ifdef PERF_SNAPSHOT_EN
        n_checks++; if (val != 100 && val != 101) begin n_fail++; $display("FAIL snap_value: got %0d expected 100 or 101", val); end
`else
        n_checks++; if (val !== mv) begin n_fail++; $display("FAIL live_value: got %0d expected %0d", val, mv); end
`endif
        repeat (12) tick;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL snap_drain: got %b expected 0", busy); end
    endtask

    task automatic test_reset_mid;
        bit found;
        int nd;
        found = 1'b0;
        nd = 0;
        out_ready = 1'b1;
        dump_req = 1'b1;
        tick;
        dump_req = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (out_valid && out_idx == 3'd4) begin
                found = 1'b1;
                break;
            end
            tick;
        end
        n_checks++; if (found !== 1'b1) begin n_fail++; $display("FAIL rmid_beat4_seen: got %b expected 1", found); end
        rst = 1'b0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_valid: got %b expected 0", out_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b expected 0", busy); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL rmid_idx: got %0d expected 0", out_idx); end
        for (int c = 0; c < 2; c++) begin
            tick;
            if (dump_done) nd++;
        end
        rst = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (dump_done || busy) nd++;
            tick;
        end
        n_checks++; if (nd !== 0) begin n_fail++; $display("FAIL rmid_no_done: got %0d expected 0", nd); end
        dump_req = 1'b1;
        tick;
        dump_req = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rmid_restart_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_idx !== 3'd0) begin n_fail++; $display("FAIL rmid_restart_idx: got %0d expected 0", out_idx); end
        repeat (12) tick;
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_drain: got %b expected 0", busy); end
    endtask

    initial begin
        test_reset;
        test_count;
        test_wrap;
        test_clear_override;
        test_dump_stall;
        test_back_to_back;
        test_snapshot;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 SHALL have parameter NUM_EVENTS, default 8, meaning the number of independent event counters (>=2).
REQ-002 SHALL have parameter CNT_WIDTH, default 48, meaning the counter width in bits (8..64).
REQ-003 SHALL have parameter INC_WIDTH, default 3, meaning the per-event per-cycle increment width (1..4).
REQ-004 SHALL have port clk  in  1  single clock; all state on posedge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port en  in  1  global count enable.
REQ-007 SHALL have port clear  in  1  synchronous clear of all counters and overflow flags.
REQ-008 SHALL have port inc  in  NUM_EVENTS*INC_WIDTH  per-event increment amount; slice i is [i*INC_WIDTH +: INC_WIDTH].
REQ-009 SHALL have port ovf  out  NUM_EVENTS  sticky per-counter wrap flag.
REQ-010 SHALL have port dump_req  in  1  request serial dump of all counters.
REQ-011 SHALL have port busy  out  1  dump in progress.
REQ-012 SHALL have port out_valid  out  1  dump beat valid.
REQ-013 SHALL have port out_ready  in  1  consumer accepts beat.
REQ-014 SHALL have port out_idx  out  max(1,$clog2(NUM_EVENTS))  index of counter in current beat.
REQ-015 SHALL have port out_data  out  CNT_WIDTH  counter value of current beat.
REQ-016 SHALL have port dump_done  out  1  one-cycle pulse after last beat accepted.

Function
REQ-017 Counter i SHALL add zero-extended inc slice i each cycle en=1 and clear=0; new value visible the following cycle.
REQ-018 Addition SHALL wrap modulo 2^CNT_WIDTH; any wrap of counter i SHALL set ovf[i], which stays set until clear or reset.
REQ-019 clear=1 SHALL zero all counters and ovf next cycle, overriding any same-cycle increment.
REQ-020 Dump FSM SHALL have states IDLE and DUMP; busy=1 exactly in DUMP.
REQ-021 IDLE: dump_req=1 SHALL transition to DUMP with out_idx=0 and out_valid=1 on the next cycle.
REQ-022 DUMP: out_valid SHALL remain 1; out_idx/out_data SHALL hold stable while out_ready=0.
REQ-023 DUMP: out_valid&out_ready SHALL advance out_idx by 1; on accept of index NUM_EVENTS-1 the FSM SHALL return to IDLE, drop out_valid, and pulse dump_done for exactly one cycle.
REQ-024 dump_req while busy SHALL be ignored (no queueing).
REQ-025 Counting SHALL continue unaffected during DUMP; clear during DUMP SHALL not abort the dump.
REQ-026 Back-to-back: dump_req in the dump_done cycle SHALL start a new dump the following cycle.

Reset
REQ-027 rst=0 SHALL asynchronously force: counters 0, ovf 0, FSM IDLE, out_idx 0, out_valid 0, busy 0, dump_done 0; out_data 0 (snapshot build) or the live value of counter 0 (non-snapshot build).
REQ-028 Reset mid-dump SHALL abandon the dump without dump_done.

Configuration
REQ-029 Macro PERF_SNAPSHOT_EN defined: on the cycle dump_req is accepted, all counter values (post-update of that cycle) SHALL be copied into a shadow bank; out_data SHALL come from the shadow, unaffected by later counting or clear.
REQ-030 PERF_SNAPSHOT_EN undefined: no shadow bank; out_data SHALL be the live value of counter out_idx.

Verification
REQ-031 NUM_EVENTS=8, INC_WIDTH=3: en=1, inc slice 2 = 5 for 10 cycles -> counter 2 = 50, all others 0, ovf=0.
REQ-032 CNT_WIDTH=8: counter 0 preloaded to 254 via counting, inc=3 -> counter 0 = 1, ovf[0]=1; clear next -> counter 0 = 0, ovf[0]=0.
REQ-033 clear=1 and inc slice 1 = 7 same cycle -> counter 1 = 0.
REQ-034 Counters 0..7 = 10..17, dump_req, out_ready toggling 1,0,1,... -> 8 beats idx 0..7 data 10..17, stable through stalls, one dump_done pulse, busy low after.
REQ-035 PERF_SNAPSHOT_EN defined: dump_req with counter 3 = 100, inc slice 3 = 1 continuously, out_ready=0 for 5 cycles -> beat idx 3 reports 100 or 101 (value at accept cycle), not later; undefined -> beat reports live value.
REQ-036 rst=0 at beat 4 of dump -> out_valid=0, busy=0 immediately, no dump_done; new dump_req after release restarts at idx 0.
